// File: rtl/icache_direct.sv
// ---------------------------------------------------------------------------
// icache_direct
//
// Direct-mapped, read-only instruction cache. It sits between the fetch stage
// and a slower backing instruction memory. Hits return combinationally in the
// same cycle. On a miss, fetch is stalled while a two-state FSM (IDLE/REFILL)
// fetches the whole line one word at a time over a level-held request /
// single-cycle valid handshake.
//
// Parameters
//   LINES     number of cache lines (power of 2, >= 2)
//   WORDS     32-bit words per line (power of 2, >= 2)
//
// Ports
//   clk        sole clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   PCF        fetch address (bits [1:0] ignored), held while StallF=1
//   FlushIC    invalidate every line (fence.i)
//   InstrF     instruction at PCF (NOP while stalled, 0 during reset)
//   StallF     1 = InstrF not valid, fetch must hold PCF
//   MemReq     refill word request, level-held during REFILL
//   MemAddr    byte address of the word being requested (0 when idle)
//   MemRData   refill data
//   MemValid   MemRData holds the word at the current MemAddr
//   HitCount   hit counter  (0 unless ICACHE_STATS_EN is defined)
//   MissCount  miss counter (0 unless ICACHE_STATS_EN is defined)
//
// Build option
//   ICACHE_STATS_EN  when defined, builds the 32-bit hit/miss counters.
//                    When undefined, both counter outputs are tied to 0.
// ---------------------------------------------------------------------------
module icache_direct #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    input  logic        FlushIC,
    output logic [31:0] InstrF,
    output logic        StallF,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic [31:0] MemRData,
    input  logic        MemValid,
    output logic [31:0] HitCount,
    output logic [31:0] MissCount
);

    localparam int OFF_W   = $clog2(WORDS);
    localparam int IDX_W   = $clog2(LINES);
    localparam int TAG_LSB = 2 + OFF_W + IDX_W;
    localparam int TAG_W   = 32 - TAG_LSB;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        S_IDLE,
        S_REFILL
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t            state_q;
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [31:0]       data_q [LINES*WORDS];
    logic [31:0]       refill_addr_q;
    logic [OFF_W-1:0]  cnt_q;
    logic              flush_pend_q;

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic [OFF_W-1:0]  pc_off;
    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic [IDX_W-1:0]  rf_idx;
    logic [TAG_W-1:0]  rf_tag;
    logic [31:0]       line_base;
    logic              unused_pc_bits;

    assign pc_off    = PCF[OFF_W+1:2];
    assign pc_idx    = PCF[TAG_LSB-1:OFF_W+2];
    assign pc_tag    = PCF[31:TAG_LSB];
    assign rf_idx    = refill_addr_q[TAG_LSB-1:OFF_W+2];
    assign rf_tag    = refill_addr_q[31:TAG_LSB];
    assign line_base = {PCF[31:OFF_W+2], {(OFF_W+2){1'b0}}};
    assign unused_pc_bits = ^PCF[1:0];

    // -----------------------------------------------------------------------
    // Lookup
    // -----------------------------------------------------------------------
    logic        idle;
    logic        hit;
    logic        miss;
    logic        last_word;
    logic        fill_en;
    logic [31:0] rd_word;

    assign idle      = (state_q == S_IDLE);
    assign hit       = idle && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign miss      = idle && !(valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag));
    assign last_word = (cnt_q == OFF_W'(WORDS - 1));
    // Reset gates the fill so a word arriving in the reset cycle is dropped.
    assign fill_en   = !rst && (state_q == S_REFILL) && MemValid;
    assign rd_word   = data_q[{pc_idx, pc_off}];

    // -----------------------------------------------------------------------
    // Outputs (combinational; reset forces the quiet values)
    // -----------------------------------------------------------------------
    always_comb begin
        InstrF  = 32'h0;
        StallF  = 1'b0;
        MemReq  = 1'b0;
        MemAddr = 32'h0;
        if (!rst) begin
            if (state_q == S_REFILL) begin
                StallF  = 1'b1;
                InstrF  = NOP;
                MemReq  = 1'b1;
                // refill_addr_q is line aligned, so the add never carries
                // into the index/tag bits.
                MemAddr = refill_addr_q + 32'({cnt_q, 2'b00});
            end else if (hit) begin
                InstrF = rd_word;
            end else begin
                StallF = 1'b1;
                InstrF = NOP;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Valid-bit next state. Flush is applied last so it overrides both the
    // miss-clear and a line completing in the same cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        if (miss) begin
            valid_d[pc_idx] = 1'b0;
        end
        if (fill_en && last_word && !flush_pend_q) begin
            valid_d[rf_idx] = 1'b1;
        end
        if (FlushIC) begin
            valid_d = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            valid_q       <= '0;
            flush_pend_q  <= 1'b0;
            refill_addr_q <= 32'h0;
        end else begin
            valid_q <= valid_d;
            case (state_q)
                S_IDLE: begin
                    if (miss) begin
                        refill_addr_q <= line_base;
                        cnt_q         <= '0;
                        // A flush coinciding with the miss must leave the
                        // line that is about to be fetched invalid.
                        flush_pend_q  <= FlushIC;
                        state_q       <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (FlushIC) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (MemValid) begin
                        cnt_q <= cnt_q + OFF_W'(1);
                        if (last_word) begin
                            flush_pend_q <= 1'b0;
                            state_q      <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Line storage (no reset: contents are qualified by valid_q)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_q[{rf_idx, cnt_q}] <= MemRData;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en && last_word) begin
            tag_q[rf_idx] <= rf_tag;
        end
    end

    // -----------------------------------------------------------------------
    // Optional statistics
    // -----------------------------------------------------------------------
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'h1;
            end
            // Every IDLE miss cycle is an IDLE->REFILL transition.
            if (miss) begin
                miss_cnt_q <= miss_cnt_q + 32'h1;
            end
        end
    end

    assign HitCount  = hit_cnt_q;
    assign MissCount = miss_cnt_q;
`else
    assign HitCount  = 32'h0;
    assign MissCount = 32'h0;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// ---------------------------------------------------------------------------
// tb_icache_direct
//
// Self-checking bench for icache_direct (default parameters). A behavioural
// backing memory returns MemAddr + 0x100 after a programmable number of wait
// cycles. Expected instructions are pushed to a scoreboard queue when a fetch
// address is driven and popped when the cache drops StallF.
// ---------------------------------------------------------------------------
module tb_icache_direct;

    localparam int WORDS = 4;
    localparam int LINES = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF;
    logic        FlushIC;
    logic [31:0] InstrF;
    logic        StallF;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic [31:0] MemRData;
    logic        MemValid;
    logic [31:0] HitCount;
    logic [31:0] MissCount;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];

    // Memory model: MemValid after mem_wait idle request cycles.
    int mem_wait = 0;
    int slow_cnt = 0;

    always #5 clk = ~clk;

    icache_direct #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .PCF      (PCF),
        .FlushIC  (FlushIC),
        .InstrF   (InstrF),
        .StallF   (StallF),
        .MemReq   (MemReq),
        .MemAddr  (MemAddr),
        .MemRData (MemRData),
        .MemValid (MemValid),
        .HitCount (HitCount),
        .MissCount(MissCount)
    );

    always_comb begin
        MemValid = MemReq && (slow_cnt == mem_wait);
        MemRData = MemAddr + 32'h100;
    end

    always @(posedge clk) begin
        if (MemReq && !MemValid) slow_cnt <= slow_cnt + 1;
        else                     slow_cnt <= 0;
    end

    // Drives one fetch and follows it until StallF drops. Checks the refill
    // word addresses, number of words, stall cycles and returned instruction.
    task automatic run_fetch(input logic [31:0] pc, input int exp_stall,
                             input int flush_at, input int exp_words);
        logic [31:0] base;
        logic [31:0] exp_i;
        logic [31:0] exp_a;
        int stalls;
        int words;
        bit done;
        base   = pc & ~32'(WORDS * 4 - 1);
        stalls = 0;
        words  = 0;
        done   = 1'b0;
        PCF    = pc;
        exp_q.push_back({pc[31:2], 2'b00} + 32'h100);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            FlushIC = (cyc == flush_at);
            @(negedge clk);
            if (MemReq) begin
                exp_a = base + 32'(4 * (words % WORDS));
                checks++;
                if (MemAddr !== exp_a) begin
                    errors++;
                    $display("FAIL memaddr pc=%h: got %h expected %h", pc, MemAddr, exp_a);
                end
                if (MemValid) words++;
            end
            if (StallF === 1'b0) begin
                done  = 1'b1;
                exp_i = exp_q.pop_front();
                checks++;
                if (InstrF !== exp_i) begin
                    errors++;
                    $display("FAIL instr pc=%h: got %h expected %h", pc, InstrF, exp_i);
                end
                checks++;
                if (MemReq !== 1'b0 || MemAddr !== 32'h0) begin
                    errors++;
                    $display("FAIL hit_quiet pc=%h: got MemReq=%b MemAddr=%h expected 0/0",
                             pc, MemReq, MemAddr);
                end
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        FlushIC = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            void'(exp_q.pop_front());
            $display("FAIL timeout pc=%h: StallF still %b after 200 cycles, expected 0", pc, StallF);
        end
        checks++;
        if (stalls != exp_stall) begin
            errors++;
            $display("FAIL stall_cycles pc=%h: got %0d expected %0d", pc, stalls, exp_stall);
        end
        checks++;
        if (words != exp_words) begin
            errors++;
            $display("FAIL refill_words pc=%h: got %0d expected %0d", pc, words, exp_words);
        end
        $display("fetch pc=%h instr=%h stalls=%0d words=%0d", pc, InstrF, stalls, words);
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        PCF     = 32'h0;
        FlushIC = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (StallF !== 1'b0 || InstrF !== 32'h0 || MemReq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got StallF=%b InstrF=%h MemReq=%b expected 0/0/0",
                     StallF, InstrF, MemReq);
        end
        checks++;
        if (HitCount !== 32'h0 || MissCount !== 32'h0) begin
            errors++;
            $display("FAIL reset_counters: got %h/%h expected 0/0", HitCount, MissCount);
        end
        $display("reset outputs StallF=%b InstrF=%h MemReq=%b", StallF, InstrF, MemReq);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_cold_miss();
        run_fetch(32'h0, WORDS + 1, -1, WORDS);
    endtask

    task automatic test_back_to_back();
        run_fetch(32'h4, 0, -1, 0);
        run_fetch(32'h8, 0, -1, 0);
        run_fetch(32'hC, 0, -1, 0);
    endtask

    task automatic test_conflict();
        run_fetch(32'h100, WORDS + 1, -1, WORDS);
        run_fetch(32'h0, WORDS + 1, -1, WORDS);
    endtask

    task automatic test_slow_memory();
        mem_wait = 2;
        run_fetch(32'h48, 1 + 3 * WORDS, -1, WORDS);
        mem_wait = 0;
        run_fetch(32'h4C, 0, -1, 0);
    endtask

    task automatic test_flush_idle();
        // Flush on a hit cycle: this lookup still hits, the next one misses.
        run_fetch(32'h4, 0, 0, 0);
        run_fetch(32'h0, WORDS + 1, -1, WORDS);
    endtask

    task automatic test_flush_refill();
        run_fetch(32'h100, WORDS + 1, -1, WORDS);
        // Flush in cycle 3 (after two words); line stays invalid and re-misses.
        run_fetch(32'h0, 2 * (WORDS + 1), 3, 2 * WORDS);
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] exp_miss;
        logic [31:0] exp_hit;
        run_fetch(32'h8, 0, 0, 0);     // flush line 0 on a hit cycle
        PCF = 32'h0;
        @(negedge clk);                // cycle 0: miss
        @(posedge clk); #1;
        @(negedge clk);                // cycle 1: word 0
        @(posedge clk); #1;
        @(negedge clk);                // cycle 2: word 1
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);                // cycle 3: reset asserted
        checks++;
        if (MemReq !== 1'b0 || StallF !== 1'b0 || InstrF !== 32'h0) begin
            errors++;
            $display("FAIL rst_in_refill: got MemReq=%b StallF=%b InstrF=%h expected 0/0/0",
                     MemReq, StallF, InstrF);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        PCF = 32'h4;
        @(negedge clk);                // cycle 4: idle miss on 0x4
        checks++;
        if (MemReq !== 1'b0 || StallF !== 1'b1) begin
            errors++;
            $display("FAIL after_rst: got MemReq=%b StallF=%b expected 0/1", MemReq, StallF);
        end
        checks++;
        if (HitCount !== 32'h0 || MissCount !== 32'h0) begin
            errors++;
            $display("FAIL after_rst_counters: got %h/%h expected 0/0", HitCount, MissCount);
        end
        $display("reset mid-refill MemReq=%b StallF=%b", MemReq, StallF);
        @(posedge clk); #1;
        run_fetch(32'h4, WORDS, -1, WORDS);
        @(negedge clk);
`ifdef ICACHE_STATS_EN
        exp_miss = 32'h1;
        exp_hit  = 32'h1;
`else
        exp_miss = 32'h0;
        exp_hit  = 32'h0;
`endif
        checks++;
        if (MissCount !== exp_miss || HitCount !== exp_hit) begin
            errors++;
            $display("FAIL stats: got hit=%h miss=%h expected hit=%h miss=%h",
                     HitCount, MissCount, exp_hit, exp_miss);
        end
        $display("stats hit=%h miss=%h", HitCount, MissCount);
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict();
        test_slow_memory();
        test_flush_idle();
        test_flush_refill();
        test_reset_mid_refill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache that answers the fetch stage's per-cycle instruction lookups and refills whole lines from a slower backing instruction memory over a request/valid handshake. It sits between the fetch stage (PC in, instruction out, stall back) and the external instruction memory, replacing the zero-latency asynchronous instruction ROM. Hits return combinationally in the same cycle. Misses stall fetch while a refill state machine fetches the line word by word.

## Interface
- `LINES`, 16: number of cache lines; power of 2, ≥2.
- `WORDS`, 4: 32-bit words per line; power of 2, ≥2.

- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `PCF` in 32: fetch address. Bits [1:0] are ignored. Fetch holds it stable while `StallF`=1.
- `FlushIC` in 1: invalidate all lines (fence.i).
- `InstrF` out 32: instruction at `PCF`.
- `StallF` out 1: 1 means `InstrF` is not valid and fetch must hold `PCF`.
- `MemReq` out 1: refill word request, level-held.
- `MemAddr` out 32: word address being requested.
- `MemRData` in 32: refill data.
- `MemValid` in 1: `MemRData` holds the word at the current `MemAddr`.
- `HitCount` out 32: hit counter (see Configuration).
- `MissCount` out 32: miss counter (see Configuration).

## Operation
- Address split:
  - offset = `PCF[log2(WORDS)+1:2]`
  - index = next log2(LINES) bits
  - tag = the remaining upper bits
- Storage: per line a valid bit, a tag and WORDS data words. Data and tag reads are asynchronous.
- FSM states: IDLE, REFILL.
- **IDLE**
  - hit = valid[index] && tag match.
  - On a hit: `InstrF` = data word, `StallF`=0.
  - On a miss: `StallF`=1 and `InstrF`=0x00000013 (NOP). At the next edge:
    - latch the line base (`PCF` with offset and byte bits cleared) into RefillAddr;
    - clear valid[index];
    - reset the word counter to 0;
    - go to REFILL.
- **REFILL**
  - `MemReq`=1 and `MemAddr` = RefillAddr + 4·counter.
  - `StallF`=1 and `InstrF`=NOP.
  - On each `MemValid`=1, write `MemRData` to word[counter] and increment the counter.
  - On `MemValid` with counter=WORDS-1:
    - write the tag;
    - set valid unless flush-pending;
    - clear flush-pending;
    - go to IDLE.
  - `MemAddr` is stable between `MemValid` pulses.
- `MemReq`=0 and `MemAddr`=0 in IDLE. `MemValid` is ignored in IDLE.
- **FlushIC**
  - In IDLE: all valid bits clear at the edge. The lookup in the same cycle still uses the old contents.
  - In REFILL: all valid bits clear and flush-pending is set. The refill completes, but the refilled line stays invalid.
  - A flush in the same cycle as a miss detection: the flush wins, and the line refilled afterwards is left invalid.
- **rst**, at the edge:
  - FSM → IDLE, counter=0, all valid=0, flush-pending=0, counters=0.
  - While `rst`=1: `StallF`=0, `InstrF`=0, `MemReq`=0.
  - Reset during REFILL abandons the refill. `MemReq` is 0 in the following cycle, and any late `MemValid` is ignored.

## Timing
- Hit latency: 0 cycles (combinational from `PCF`).
- Miss with zero-wait memory (`MemValid`=1 every REFILL cycle):
  - cycle 0: miss, `StallF`=1.
  - cycles 1..WORDS: REFILL.
  - cycle WORDS+1: hit, `StallF`=0.
  - Penalty is WORDS+1 cycles.
- General miss penalty: 1 + (number of REFILL cycles) + 0.
- At most one outstanding word request. The memory must not assert `MemValid` without `MemReq`.

## Configuration
- `ICACHE_STATS_EN` defined:
  - `HitCount` increments on each IDLE hit cycle and `MissCount` increments on each IDLE→REFILL transition.
  - Both counters are 32-bit, wrap modulo 2^32, and are cleared by `rst`.
- Not defined: no counter logic is built and both outputs are tied to 0. The port list is identical in both builds.

## Test plan
Default parameters; model memory returns `MemAddr`+0x100.

- Post-reset fetch: `PCF`=0x0, zero-wait memory → `StallF`=1 in cycles 0–4; `MemAddr`=0x0/0x4/0x8/0xC in cycles 1–4; cycle 5 `InstrF`=0x100, `StallF`=0.
- Line hits: `PCF`=0x4, 0x8, 0xC on consecutive cycles → `InstrF`=0x104, 0x108, 0x10C with `StallF`=0 and no `MemReq`.
- Conflict: `PCF`=0x100 (index 0, tag 1) → 5-cycle miss, `InstrF`=0x200; then `PCF`=0x0 → miss again with `MemAddr` starting at 0x0.
- Slow memory: `MemValid` on every 3rd REFILL cycle → 12 REFILL cycles, `MemReq` held high, `MemAddr` constant between pulses; `InstrF` is correct afterwards.
- Flush:
  - `FlushIC` in IDLE with line 0 valid → the next access to 0x0 misses.
  - `FlushIC` after 2 refill words → 4 words complete, `StallF` stays 1, and an immediate re-miss refills 0x0 again.
- Reset mid-refill: `rst` after 2 words → `MemReq`=0 next cycle, `PCF`=0x4 misses; with `ICACHE_STATS_EN`, `HitCount`=`MissCount`=0 after reset and `MissCount`=1 after that miss.
